y_huff_bitreader: RTL and testbench

- Bit-level front end of the Y (luma) Huffman decoder.
- Accepts packed 32-bit MSB-first JPEG bitstream words, in the same form y_huff emits them (JPEG_bitstream plus a valid-bit count).
- Buffers the words and presents a 16-bit peek window to the downstream Huffman code-table lookup.
- On a consume request, removes code_len+size bits and returns the sign-decoded JPEG amplitude of the trailing size bits.

---
 rtl/y_huff_bitreader_if.sv | 44 ++++
 rtl/y_huff_bitreader.sv | 133 +++++++++++++
 tb/tb_y_huff_bitreader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/y_huff_bitreader_if.sv
// Bitstream/consume interface of the Y Huffman bit reader.
//   master: bitstream source and code-table lookup
//   slave : y_huff_bitreader
// Signal groups:
//   in_*         packed MSB-first word input (valid/ready)
//   peek_*       16-bit look-ahead window and buffered bit count
//   cons_*       consume request (code_len + size bits, valid/ready)
//   amp_*        decoded amplitude, one-cycle pulse
//   drained, err block-end and sticky illegal-request status
interface y_huff_bitreader_if #(
    parameter int PEEK_W = 16,
    parameter int AMP_W  = 12,
    parameter int CNT_W  = 7
);
    logic [31:0]       in_word;
    logic [5:0]        in_bits;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [PEEK_W-1:0] peek_bits;
    logic [CNT_W-1:0]  peek_avail;
    logic              cons_valid;
    logic [4:0]        cons_code_len;
    logic [3:0]        cons_size;
    logic              cons_ready;
    logic              amp_valid;
    logic [AMP_W-1:0]  amp;
    logic              drained;
    logic              err;

    modport master (
        output in_word, in_bits, in_last, in_valid,
        output cons_valid, cons_code_len, cons_size,
        input  in_ready, peek_bits, peek_avail, cons_ready,
        input  amp_valid, amp, drained, err
    );

    modport slave (
        input  in_word, in_bits, in_last, in_valid,
        input  cons_valid, cons_code_len, cons_size,
        output in_ready, peek_bits, peek_avail, cons_ready,
        output amp_valid, amp, drained, err
    );
endinterface

// File: rtl/y_huff_bitreader.sv
// Bit-level front end of the Y (luma) Huffman decoder.
// Collects packed MSB-first bitstream words into a bit buffer, exposes a
// 16-bit peek window for the code-table lookup, and on a consume request
// drops code_len+size bits while returning the JPEG sign-decoded amplitude
// of the trailing size bits.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  y_huff_bitreader_if.slave (word input, peek, consume, status)
module y_huff_bitreader #(
    parameter int BUF_W  = 64,
    parameter int PEEK_W = 16,
    parameter int AMP_W  = 12
) (
    input  logic clk,
    input  logic rst,
    y_huff_bitreader_if.slave bus
);
    localparam int CNT_W  = $clog2(BUF_W + 1);
    localparam int IDX_W  = $clog2(BUF_W);
    localparam int SIZE_W = AMP_W - 1;

    // Buffer is MSB-aligned: oldest bit at [BUF_W-1]; bits at positions
    // >= bit_cnt are always kept zero so new words can simply be OR-ed in.
    logic [BUF_W-1:0] bit_buf;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_seen;
    logic             amp_valid_q;
    logic [AMP_W-1:0] amp_q;
    logic             drained_q;
    logic             err_q;

    logic             cons_legal;
    logic [CNT_W-1:0] cons_n;
    logic             cons_ok;
    logic             cons_fire;
    logic             in_ok;
    logic             in_fire;
    logic [5:0]       eff_bits;
    logic [31:0]      word_clean;
    logic [CNT_W-1:0] shift_n;
    logic [BUF_W-1:0] buf_shift;
    logic [CNT_W-1:0] cnt_shift;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             last_next;
    logic [IDX_W-1:0] amp_msb;
    logic [SIZE_W-1:0] amp_field;
    logic [SIZE_W-1:0] amp_v;
    logic [AMP_W-1:0] amp_dec;
    logic [PEEK_W-1:0] peek_mask;

    assign cons_legal = (bus.cons_code_len <= 5'd16) && (bus.cons_size <= 4'(SIZE_W));
    assign cons_n     = CNT_W'(bus.cons_code_len) + CNT_W'(bus.cons_size);
    assign cons_ok    = cons_legal && (bit_cnt >= cons_n);
    assign cons_fire  = bus.cons_valid && cons_ok;
    assign in_ok      = (bit_cnt <= CNT_W'(32));
    assign in_fire    = bus.in_valid && in_ok;

    always_comb begin
        eff_bits = bus.in_bits;
        if (bus.in_bits == 6'd0 || bus.in_bits > 6'd32)
            eff_bits = 6'd32;
        // Keep only the left-justified valid bits; a shift by 32 yields an all-ones mask.
        word_clean = bus.in_word & ~(32'hFFFF_FFFF >> eff_bits);
    end

    // Consume shift happens first, then the new word lands behind what is left.
    always_comb begin
        shift_n   = cons_fire ? cons_n : '0;
        buf_shift = bit_buf << shift_n;
        cnt_shift = bit_cnt - shift_n;
        buf_next  = buf_shift;
        cnt_next  = cnt_shift;
        last_next = last_seen;
        if (in_fire) begin
            buf_next  = buf_shift | ({word_clean, {(BUF_W-32){1'b0}}} >> cnt_shift);
            cnt_next  = cnt_shift + CNT_W'(eff_bits);
            last_next = bus.in_last;
        end
    end

    // Amplitude field starts right after the code bits; right-justify it to size bits.
    always_comb begin
        amp_msb   = IDX_W'(BUF_W - 1) - IDX_W'(bus.cons_code_len);
        amp_field = bit_buf[amp_msb -: SIZE_W];
        amp_v     = amp_field >> (4'(SIZE_W) - bus.cons_size);
        amp_dec   = '0;
        if (bus.cons_size != 4'd0) begin
            if (amp_field[SIZE_W-1])
                amp_dec = AMP_W'(amp_v);
            else
                amp_dec = AMP_W'(amp_v) - ((AMP_W'(1) << bus.cons_size) - AMP_W'(1));
        end
    end

    always_comb begin
        peek_mask = '1;
        if (bit_cnt < CNT_W'(PEEK_W))
            peek_mask = ~({PEEK_W{1'b1}} >> bit_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_buf     <= '0;
            bit_cnt     <= '0;
            last_seen   <= 1'b0;
            amp_valid_q <= 1'b0;
            amp_q       <= '0;
            drained_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bit_buf     <= buf_next;
            bit_cnt     <= cnt_next;
            last_seen   <= last_next;
            amp_valid_q <= cons_fire;
            if (cons_fire)
                amp_q <= amp_dec;
            drained_q   <= last_next && (cnt_next == '0);
            if (bus.cons_valid && !cons_legal)
                err_q <= 1'b1;
        end
    end

    assign bus.in_ready   = in_ok;
    assign bus.cons_ready = cons_ok;
    assign bus.peek_bits  = bit_buf[BUF_W-1 -: PEEK_W] & peek_mask;
    assign bus.peek_avail = bit_cnt;
    assign bus.amp_valid  = amp_valid_q;
    assign bus.amp        = amp_q;
    assign bus.drained    = drained_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_y_huff_bitreader.sv
// Directed self-checking bench for y_huff_bitreader.
module tb_y_huff_bitreader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    y_huff_bitreader_if bus ();

    y_huff_bitreader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w, input logic [5:0] b, input logic l);
        bus.in_word  = w;
        bus.in_bits  = b;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
    endtask

    task automatic cons(input logic [4:0] cl, input logic [3:0] sz);
        bus.cons_code_len = cl;
        bus.cons_size     = sz;
        bus.cons_valid    = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.cons_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0;
        bus.in_word = '0; bus.in_bits = '0; bus.in_last = 1'b0; bus.in_valid = 1'b0;
        bus.cons_valid = 1'b0; bus.cons_code_len = '0; bus.cons_size = '0;
        tick(); tick();
        check("rst_peek", bus.peek_bits, 16'h0000);
        check("rst_avail", bus.peek_avail, 7'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_amp_valid", bus.amp_valid, 1'b0);
        check("rst_amp", bus.amp, 12'h000);
        check("rst_drained", bus.drained, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b1;
        tick();

        // First word and two consumes
        load(32'hA500_0000, 6'd8, 1'b0);
        tick(); idle();
        check("w1_peek", bus.peek_bits, 16'hA500);
        check("w1_avail", bus.peek_avail, 7'd8);
        cons(5'd2, 4'd3);
        #1 check("c1_ready", bus.cons_ready, 1'b1);
        tick(); idle();
        check("c1_amp_valid", bus.amp_valid, 1'b1);
        check("c1_amp", bus.amp, 12'd4);
        check("c1_avail", bus.peek_avail, 7'd3);
        check("c1_peek", bus.peek_bits, 16'hA000);
        cons(5'd0, 4'd3);
        tick(); idle();
        check("c2_amp", bus.amp, 12'd5);
        check("c2_avail", bus.peek_avail, 7'd0);
        tick();
        check("c2_amp_valid_drop", bus.amp_valid, 1'b0);
        check("c2_amp_hold", bus.amp, 12'd5);

        // Negative amplitudes
        load(32'h6000_0000, 6'd3, 1'b0);
        tick(); idle();
        cons(5'd0, 4'd3);
        tick(); idle();
        check("neg4_amp", bus.amp, 12'hFFC);
        load(32'h0000_0000, 6'd1, 1'b0);
        tick(); idle();
        cons(5'd0, 4'd1);
        tick(); idle();
        check("neg1_amp", bus.amp, 12'hFFF);
        check("neg1_avail", bus.peek_avail, 7'd0);

        // Fill to 64 (in_bits=0 counts as 32), drain in 16-bit steps
        load(32'hFFFF_0000, 6'd0, 1'b0);
        tick();
        check("fill1_avail", bus.peek_avail, 7'd32);
        check("fill1_in_ready", bus.in_ready, 1'b1);
        load(32'h1234_5678, 6'd32, 1'b0);
        tick(); idle();
        check("fill2_avail", bus.peek_avail, 7'd64);
        check("fill2_in_ready", bus.in_ready, 1'b0);
        check("fill2_peek", bus.peek_bits, 16'hFFFF);
        cons(5'd16, 4'd0);
        tick();
        check("d48_avail", bus.peek_avail, 7'd48);
        check("d48_in_ready", bus.in_ready, 1'b0);
        check("d48_amp", bus.amp, 12'd0);
        tick(); idle();
        check("d32_in_ready", bus.in_ready, 1'b1);
        check("d32_peek", bus.peek_bits, 16'h1234);
        cons(5'd16, 4'd0);
        tick(); tick(); idle();
        check("d0_avail", bus.peek_avail, 7'd0);

        // Simultaneous load and consume
        load(32'hABCD_E000, 6'd20, 1'b0);
        tick(); idle();
        check("sim_pre_avail", bus.peek_avail, 7'd20);
        load(32'h5A5A_5A5A, 6'd32, 1'b0);
        cons(5'd10, 4'd0);
        tick(); idle();
        check("sim_avail", bus.peek_avail, 7'd42);
        check("sim_peek", bus.peek_bits, 16'h3796);
        cons(5'd10, 4'd0);
        tick(); idle();
        check("sim_new_peek", bus.peek_bits, 16'h5A5A);
        cons(5'd16, 4'd0);
        tick(); tick(); idle();
        check("sim_empty", bus.peek_avail, 7'd0);

        // Ignored low bits and oversize in_bits
        load(32'hFFFF_FFFF, 6'd4, 1'b0);
        tick(); idle();
        check("mask_peek", bus.peek_bits, 16'hF000);
        check("mask_avail", bus.peek_avail, 7'd4);
        cons(5'd4, 4'd0);
        tick(); idle();
        load(32'h0000_0001, 6'd40, 1'b0);
        tick(); idle();
        check("big_avail", bus.peek_avail, 7'd32);
        cons(5'd16, 4'd0);
        tick();
        cons(5'd15, 4'd1);
        tick(); idle();
        check("big_last_amp", bus.amp, 12'd1);
        check("big_empty", bus.peek_avail, 7'd0);

        // Illegal request
        cons(5'd17, 4'd0);
        #1 check("ill_ready", bus.cons_ready, 1'b0);
        tick(); idle();
        check("ill_err", bus.err, 1'b1);
        check("ill_no_amp", bus.amp_valid, 1'b0);
        tick();
        check("ill_err_sticky", bus.err, 1'b1);

        // Request larger than buffered bits
        load(32'hC300_0000, 6'd8, 1'b0);
        tick(); idle();
        cons(5'd4, 4'd8);
        #1 check("short_ready", bus.cons_ready, 1'b0);
        tick();
        check("short_no_amp", bus.amp_valid, 1'b0);
        check("short_avail", bus.peek_avail, 7'd8);
        load(32'h8000_0000, 6'd4, 1'b0);
        #1 check("short_same_cycle_ready", bus.cons_ready, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("short_still_no_amp", bus.amp_valid, 1'b0);
        check("short_avail12", bus.peek_avail, 7'd12);
        #1 check("short_ready_now", bus.cons_ready, 1'b1);
        tick(); idle();
        check("short_amp_valid", bus.amp_valid, 1'b1);
        check("short_amp", bus.amp, 12'hF39);
        check("short_empty", bus.peek_avail, 7'd0);

        // Block end
        load(32'h8000_0000, 6'd1, 1'b1);
        tick(); idle();
        check("last_not_drained", bus.drained, 1'b0);
        cons(5'd0, 4'd1);
        tick(); idle();
        check("last_amp", bus.amp, 12'd1);
        check("drained_set", bus.drained, 1'b1);
        tick();
        check("drained_hold", bus.drained, 1'b1);
        load(32'hF000_0000, 6'd32, 1'b0);
        tick(); idle();
        check("drained_clr", bus.drained, 1'b0);
        load(32'hAA00_0000, 6'd8, 1'b0);
        tick(); idle();
        check("pre_rst_avail", bus.peek_avail, 7'd40);

        // Asynchronous reset mid-buffer
        #3 rst = 1'b0;
        #1;
        check("arst_avail", bus.peek_avail, 7'd0);
        check("arst_peek", bus.peek_bits, 16'h0000);
        check("arst_amp", bus.amp, 12'h000);
        check("arst_err", bus.err, 1'b0);
        check("arst_drained", bus.drained, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        tick();
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
